// File: rtl/writeback_stage.sv
// writeback_stage: queues ALU and load results and drains them into the register file.
// Each write holds rdwrite for two cycles, then leaves a gap. Define WB_BYPASS_EN to enable forwarding from pending writes.
module writeback_stage #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    output logic [4:0]  selRD,
    output logic [31:0] data_in,
    output logic        rdwrite,
    input  logic [4:0]  byp_rs1,
    input  logic [4:0]  byp_rs2,
    output logic        byp_hit1,
    output logic        byp_hit2,
    output logic [31:0] byp_data1,
    output logic [31:0] byp_data2,
    output logic        wb_idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WR1, WR2, GAP} state_t;
    state_t state, next_state;

    logic [4:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic          not_full, push, pop;
    logic [4:0]    push_rd;
    logic [31:0]   push_data;
    logic          rdwrite_nxt;
    logic [4:0]    sel_nxt;
    logic [31:0]   data_nxt;

    // Ready looks only at the registered count, so a pop never frees a slot in the same cycle.
    assign not_full  = count < CW'(DEPTH);
    assign lsu_ready = not_full;
    assign alu_ready = not_full && !lsu_valid;
    assign wb_idle   = (count == '0) && (state == IDLE);

    // rd==0 handshakes complete normally but leave nothing in the queue.
    always_comb begin
        push      = 1'b0;
        push_rd   = lsu_rd;
        push_data = lsu_data;
        if (lsu_valid && lsu_ready) begin
            push = (lsu_rd != 5'd0);
        end else if (alu_valid && alu_ready) begin
            push      = (alu_rd != 5'd0);
            push_rd   = alu_rd;
            push_data = alu_data;
        end
    end

    assign pop = ((state == IDLE) || (state == GAP)) && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= push_rd;
            q_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (count != '0) next_state = WR1;
            WR1:     next_state = WR2;
            WR2:     next_state = GAP;
            GAP:     next_state = (count != '0) ? WR1 : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Register-file port values are computed here and registered below so they change only on an edge.
    always_comb begin
        rdwrite_nxt = (next_state == WR1) || (next_state == WR2);
        sel_nxt     = selRD;
        data_nxt    = data_in;
        if (pop) begin
            sel_nxt  = q_rd[rd_ptr];
            data_nxt = q_data[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            selRD   <= '0;
            data_in <= '0;
            rdwrite <= 1'b0;
        end else begin
            selRD   <= sel_nxt;
            data_in <= data_nxt;
            rdwrite <= rdwrite_nxt;
        end
    end

`ifdef WB_BYPASS_EN
    logic [1:0][4:0]  rs;
    logic [1:0]       hit;
    logic [1:0][31:0] fwd;

    assign rs[0] = byp_rs1;
    assign rs[1] = byp_rs2;

    // Scan oldest to youngest so the last match wins; the entry being written is older than anything queued.
    always_comb begin
        hit = '0;
        fwd = '0;
        for (int p = 0; p < 2; p++) begin
            if (rs[p] != 5'd0) begin
                if (((state == WR1) || (state == WR2)) && (selRD == rs[p])) begin
                    hit[p] = 1'b1;
                    fwd[p] = data_in;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if ((CW'(i) < count) && (q_rd[rd_ptr + PW'(i)] == rs[p])) begin
                        hit[p] = 1'b1;
                        fwd[p] = q_data[rd_ptr + PW'(i)];
                    end
                end
            end
        end
    end

    assign byp_hit1  = hit[0];
    assign byp_hit2  = hit[1];
    assign byp_data1 = fwd[0];
    assign byp_data2 = fwd[1];
`else
    logic byp_unused;
    assign byp_unused = ^{byp_rs1, byp_rs2};
    assign byp_hit1   = 1'b0;
    assign byp_hit2   = 1'b0;
    assign byp_data1  = '0;
    assign byp_data2  = '0;
`endif

endmodule
